sew_operand_streamer: RTL and testbench
=======================================

Name: sew_operand_streamer

Overview:
- Sequential successor to the combinational SEW operand packer.
- Latches two full vector operands (A, B) plus SEW and vl, then streams them to the multiplier as DATA_W-wide beats under a valid/ready handshake.
- Each beat carries a per-byte active mask; tail elements beyond vl are zeroed.
- Sits between the vector register file read port and the multiplier datapath.

Parameters:
- VLEN, 512, vector register width in bits; multiple of DATA_W.
- DATA_W, 32, beat width in bits (multiplier lane width); multiple of 32.
- VL_W, $clog2(VLEN/8)+1, width of vl.
- BEATS_W, $clog2(VLEN/DATA_W), width of beat index; minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a new transfer; sampled only in IDLE
- sew  in  2  element width: 00=8, 01=16, 10=32, 11=illegal
- vl  in  VL_W  active element count
- op_a  in  VLEN  vector operand A, sampled with start
- op_b  in  VLEN  vector operand B, sampled with start
- beat_valid  out  1  beat outputs valid
- beat_ready  in  1  consumer accepts beat
- beat_a  out  DATA_W  operand A slice, inactive bytes zero
- beat_b  out  DATA_W  operand B slice, inactive bytes zero
- beat_mask  out  DATA_W/8  per-byte active flag
- beat_idx  out  BEATS_W  index of current beat
- beat_sew  out  2  latched sew, forwarded to the multiplier
- beat_last  out  1  final beat of transfer
- busy  out  1  high in STREAM and DONE
- done  out  1  one-cycle pulse at transfer completion
- sew_err  out  1  one-cycle pulse on start with sew=11

Behaviour:
- Reset: all outputs 0; state=IDLE; latched operands cleared. Reset has priority over every other event, including mid-stream; any beat in flight is dropped.
- SEW bytes: sb = 1, 2 or 4. VLMAX = VLEN/(8*sb). vl_eff = min(vl, VLMAX).
- Transfer size: active_bytes = vl_eff*sb. total_beats = ceil(active_bytes/(DATA_W/8)).
- IDLE:
  - start && sew==11 → sew_err=1 next cycle; remain IDLE.
  - start && vl_eff==0 → DONE (done=1 next cycle); no beats issued.
  - start otherwise → latch op_a, op_b, sew, vl_eff; go to STREAM. beat_valid=1 and beat_idx=0 the next cycle (registered outputs; latency 1).
- STREAM:
  - Beat k: beat_a = op_a[k*DATA_W +: DATA_W] with inactive bytes forced to 0; same rule for beat_b.
  - beat_mask[b] = ((k*DATA_W/8 + b) < active_bytes).
  - beat_last = (k == total_beats-1).
  - All beat_* outputs hold stable while beat_valid && !beat_ready.
  - Handshake = beat_valid && beat_ready. On handshake of a non-last beat, advance k in the same edge, so back-to-back beats run at one per cycle. On handshake of the last beat, beat_valid=0 and state goes to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. A start arriving in that cycle is ignored.
- start while busy is ignored; sew_err is not raised.
- beat_ready while beat_valid=0 has no effect.
- vl > VLMAX clamps silently to VLMAX.

Decomposition:
- Shared package vec_mul_pkg holds:
  - typedef sew_e (SEW_8=2'b00, SEW_16=2'b01, SEW_32=2'b10, SEW_ILL=2'b11)
  - typedef stream_state_e (IDLE, STREAM, DONE)
  - function sew_bytes(sew_e)
- One sub-module, sew_tail_masker: combinational; takes a beat slice, beat index and active_bytes; produces the masked slice and beat_mask. Instantiate it twice (A and B) or share the mask.

Test Plan (VLEN=128, DATA_W=32):
- Full byte stream: sew=00, vl=16, op_a byte i = i → 4 beats; beat0 a=0x03020100, beat3 a=0x0F0E0D0C; mask=4'hF on all beats; beat_last on beat 3; done one cycle after the beat-3 handshake.
- Tail zeroing: sew=01, vl=3, op_a=all 0xFF → 2 beats; beat1 a=0x0000FFFF, mask=4'b0011, beat_last=1.
- Backpressure: beat_ready low for 3 cycles at beat 1 → beat_a, beat_idx=1 and beat_mask stay constant; advance to beat 2 on the cycle ready rises.
- Empty and clamp:
  - vl=0 → beat_valid never asserts; done pulse at cycle 1.
  - sew=10, vl=20 → clamps to 4 beats.
- Errors and ignores:
  - sew=11 with start → sew_err pulse, busy stays 0.
  - start during STREAM → ignored; the original transfer completes unchanged.
- Mid-stream reset: reset asserted while beat 2 is pending → next cycle all outputs 0; a new start then streams correctly from beat 0.

Source files
------------

// File: rtl/vec_mul_pkg.sv
// Shared types and helpers for the vector multiplier front end.
package vec_mul_pkg;

   typedef enum logic [1:0] {
      SEW_8   = 2'b00,
      SEW_16  = 2'b01,
      SEW_32  = 2'b10,
      SEW_ILL = 2'b11
   } sew_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      STREAM = 2'b01,
      DONE   = 2'b10
   } stream_state_e;

   // Element size in bytes; 0 marks the illegal encoding.
   function automatic logic [2:0] sew_bytes(input sew_e s);
      logic [2:0] r;
      case (s)
         SEW_8:   r = 3'd1;
         SEW_16:  r = 3'd2;
         SEW_32:  r = 3'd4;
         default: r = 3'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sew_tail_masker.sv
// Zeroes the bytes of one beat that lie at or beyond the active byte count
// and reports which bytes of the beat are active.
module sew_tail_masker #(
   parameter int DATA_W  = 32,
   parameter int VL_W    = 7,
   parameter int BEATS_W = 4
) (
   input  logic [DATA_W-1:0]   i_slice,
   input  logic [BEATS_W-1:0]  i_idx,
   input  logic [VL_W-1:0]     i_active_bytes,
   output logic [DATA_W-1:0]   o_slice,
   output logic [DATA_W/8-1:0] o_mask
);

   localparam int BPB = DATA_W / 8;

   // Byte b of beat idx is active when its global byte position is below active_bytes.
   always_comb begin
      o_slice = '0;
      o_mask  = '0;
      for (int b = 0; b < BPB; b++) begin
         if ((32'(i_idx) * BPB + b) < 32'(i_active_bytes)) begin
            o_mask[b]         = 1'b1;
            o_slice[b*8 +: 8] = i_slice[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/sew_operand_streamer.sv
// Latches two vector operands with their SEW and vl, then streams them to
// the multiplier as DATA_W-wide beats under a valid/ready handshake.
// Handshake: a beat transfers on a rising clk edge where o_beat_valid and
// i_beat_ready are both high; while valid is high and ready is low every
// o_beat_* output holds its value; ready while valid is low is ignored.
module sew_operand_streamer
   import vec_mul_pkg::*;
#(
   parameter int VLEN    = 512,
   parameter int DATA_W  = 32,
   parameter int VL_W    = $clog2(VLEN/8) + 1,
   parameter int BEATS_W = ((VLEN/DATA_W) > 1) ? $clog2(VLEN/DATA_W) : 1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [1:0]          i_sew,
   input  logic [VL_W-1:0]     i_vl,
   input  logic [VLEN-1:0]     i_op_a,
   input  logic [VLEN-1:0]     i_op_b,
   output logic                o_beat_valid,
   input  logic                i_beat_ready,
   output logic [DATA_W-1:0]   o_beat_a,
   output logic [DATA_W-1:0]   o_beat_b,
   output logic [DATA_W/8-1:0] o_beat_mask,
   output logic [BEATS_W-1:0]  o_beat_idx,
   output logic [1:0]          o_beat_sew,
   output logic                o_beat_last,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_sew_err,
   output logic [1:0]          o_dbg_state
);

   localparam int BPB    = DATA_W / 8;
   localparam int VLEN_B = VLEN / 8;

   stream_state_e       r_state;
   logic [VLEN-1:0]     r_op_a;
   logic [VLEN-1:0]     r_op_b;
   logic [1:0]          r_sew;
   logic [VL_W-1:0]     r_active;
   logic [BEATS_W-1:0]  r_idx;
   logic [BEATS_W-1:0]  r_last_idx;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;
   logic                r_sew_err;

   logic [2:0]          w_sb;
   logic [VL_W-1:0]     w_vlmax;
   logic [VL_W-1:0]     w_vl_eff;
   logic [VL_W-1:0]     w_active;
   logic [BEATS_W-1:0]  w_last_idx;
   logic                w_handshake;
   logic [DATA_W-1:0]   w_slice_a;
   logic [DATA_W-1:0]   w_slice_b;
   logic [DATA_W/8-1:0] w_mask_a;
   logic [DATA_W/8-1:0] w_mask_b;

   // Decode the requested transfer size from the live start inputs.
   always_comb begin
      w_sb    = sew_bytes(sew_e'(i_sew));
      w_vlmax = '0;
      case (w_sb)
         3'd1:    w_vlmax = VL_W'(VLEN_B);
         3'd2:    w_vlmax = VL_W'(VLEN_B / 2);
         3'd4:    w_vlmax = VL_W'(VLEN_B / 4);
         default: w_vlmax = '0;
      endcase
      w_vl_eff   = (i_vl < w_vlmax) ? i_vl : w_vlmax;
      w_active   = VL_W'(32'(w_vl_eff) * 32'(w_sb));
      // Only used when w_active is non-zero, so the underflow at zero is harmless.
      w_last_idx = BEATS_W'((32'(w_active) + BPB - 1) / BPB - 1);
   end

   assign w_handshake = r_valid && i_beat_ready;

   // Transfer FSM with all control outputs registered.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_sew      <= '0;
         r_active   <= '0;
         r_idx      <= '0;
         r_last_idx <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sew_err  <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_sew_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  if (sew_e'(i_sew) == SEW_ILL) begin
                     r_sew_err <= 1'b1;
                  end else if (w_vl_eff == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state    <= STREAM;
                     r_op_a     <= i_op_a;
                     r_op_b     <= i_op_b;
                     r_sew      <= i_sew;
                     r_active   <= w_active;
                     r_last_idx <= w_last_idx;
                     r_idx      <= '0;
                     r_valid    <= 1'b1;
                     r_busy     <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (w_handshake) begin
                  if (r_idx == r_last_idx) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Beat slices come straight from the latched operands, so they hold under backpressure.
   assign w_slice_a = r_op_a[32'(r_idx) * DATA_W +: DATA_W];
   assign w_slice_b = r_op_b[32'(r_idx) * DATA_W +: DATA_W];

   sew_tail_masker #(
      .DATA_W  (DATA_W),
      .VL_W    (VL_W),
      .BEATS_W (BEATS_W)
   ) u_mask_a (
      .i_slice        (w_slice_a),
      .i_idx          (r_idx),
      .i_active_bytes (r_active),
      .o_slice        (o_beat_a),
      .o_mask         (w_mask_a)
   );

   sew_tail_masker #(
      .DATA_W  (DATA_W),
      .VL_W    (VL_W),
      .BEATS_W (BEATS_W)
   ) u_mask_b (
      .i_slice        (w_slice_b),
      .i_idx          (r_idx),
      .i_active_bytes (r_active),
      .o_slice        (o_beat_b),
      .o_mask         (w_mask_b)
   );

   // Both masks are identical by construction; combining them keeps both instances used.
   assign o_beat_mask  = w_mask_a & w_mask_b;
   assign o_beat_valid = r_valid;
   assign o_beat_idx   = r_idx;
   assign o_beat_sew   = r_sew;
   assign o_beat_last  = r_valid && (r_idx == r_last_idx);
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_sew_err    = r_sew_err;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sew_operand_streamer.sv
// Bench for sew_operand_streamer at VLEN=128, DATA_W=32.
module tb_sew_operand_streamer;

   localparam int VLEN    = 128;
   localparam int DATA_W  = 32;
   localparam int VL_W    = 5;
   localparam int BEATS_W = 2;

   logic               clk = 1'b0;
   logic               i_reset = 1'b1;
   logic               i_start = 1'b0;
   logic [1:0]         i_sew = '0;
   logic [VL_W-1:0]    i_vl = '0;
   logic [VLEN-1:0]    i_op_a = '0;
   logic [VLEN-1:0]    i_op_b = '0;
   logic               i_beat_ready = 1'b0;
   logic               o_beat_valid;
   logic [DATA_W-1:0]  o_beat_a;
   logic [DATA_W-1:0]  o_beat_b;
   logic [3:0]         o_beat_mask;
   logic [BEATS_W-1:0] o_beat_idx;
   logic [1:0]         o_beat_sew;
   logic               o_beat_last;
   logic               o_busy;
   logic               o_done;
   logic               o_sew_err;
   logic [1:0]         o_dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_a_q[$];
   logic [31:0] exp_b_q[$];
   logic [3:0]  exp_m_q[$];

   sew_operand_streamer #(
      .VLEN(VLEN), .DATA_W(DATA_W), .VL_W(VL_W), .BEATS_W(BEATS_W)
   ) dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_sew(i_sew), .i_vl(i_vl),
      .i_op_a(i_op_a), .i_op_b(i_op_b), .o_beat_valid(o_beat_valid),
      .i_beat_ready(i_beat_ready), .o_beat_a(o_beat_a), .o_beat_b(o_beat_b),
      .o_beat_mask(o_beat_mask), .o_beat_idx(o_beat_idx), .o_beat_sew(o_beat_sew),
      .o_beat_last(o_beat_last), .o_busy(o_busy), .o_done(o_done),
      .o_sew_err(o_sew_err), .o_dbg_state(o_dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: per-beat expected slices from the element/byte rules.
   function automatic int model_load(input logic [1:0] s, input logic [4:0] v,
                                     input logic [127:0] a, input logic [127:0] b);
      int sb, vlmax, ve, act, total, g;
      logic [31:0] wa, wb;
      logic [3:0]  m;
      sb    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      vlmax = 16 / sb;
      ve    = (int'(v) < vlmax) ? int'(v) : vlmax;
      act   = ve * sb;
      total = (act + 3) / 4;
      exp_a_q.delete(); exp_b_q.delete(); exp_m_q.delete();
      for (int k = 0; k < total; k++) begin
         wa = '0; wb = '0; m = '0;
         for (int j = 0; j < 4; j++) begin
            g = k * 4 + j;
            if (g < act) begin
               wa[j*8 +: 8] = a[g*8 +: 8];
               wb[j*8 +: 8] = b[g*8 +: 8];
               m[j] = 1'b1;
            end
         end
         exp_a_q.push_back(wa); exp_b_q.push_back(wb); exp_m_q.push_back(m);
      end
      return total;
   endfunction

   // Driver + scoreboard for one full transfer.
   task automatic run_xfer(input logic [1:0] s, input logic [4:0] v, input logic [127:0] a,
                           input logic [127:0] b, input int ready_pct, input bit poke,
                           output int nb, output logic [31:0] fa, output logic [31:0] la,
                           output logic [3:0] lm);
      int cyc, total;
      bit exp_done, lastb;
      nb = 0; fa = '0; la = '0; lm = '0;
      total = model_load(s, v, a, b);
      @(negedge clk);
      i_start = 1'b1; i_sew = s; i_vl = v; i_op_a = a; i_op_b = b;
      @(negedge clk);
      i_start = 1'b0;
      exp_done = (total == 0);
      cyc = 0;
      while (1) begin
         i_start = 1'b0;
         if (cyc > 300) begin
            chk(1'b0, "timeout", cyc, 300);
            break;
         end
         chk(o_sew_err == 1'b0, "sew_err_quiet", o_sew_err, 0);
         if (exp_done) begin
            chk(o_done == 1'b1, "done_pulse", o_done, 1);
            chk(o_busy == 1'b1, "busy_in_done", o_busy, 1);
            chk(o_beat_valid == 1'b0, "valid_in_done", o_beat_valid, 0);
            i_beat_ready = 1'b0;
            if (poke) begin
               i_start = 1'b1; i_sew = 2'b00; i_vl = 5'd16;
            end
            @(negedge clk);
            i_start = 1'b0;
            chk(o_done == 1'b0, "done_one_cycle", o_done, 0);
            chk(o_busy == 1'b0, "busy_back_idle", o_busy, 0);
            chk(o_beat_valid == 1'b0, "valid_idle", o_beat_valid, 0);
            break;
         end
         chk(o_done == 1'b0, "done_early", o_done, 0);
         chk(o_busy == 1'b1, "busy_stream", o_busy, 1);
         chk(o_beat_valid == 1'b1, "valid_stream", o_beat_valid, 1);
         if (o_beat_valid) begin
            if (exp_a_q.size() == 0) begin
               chk(1'b0, "extra_beat", o_beat_idx, nb);
               break;
            end
            chk(o_beat_a == exp_a_q[0], "beat_a", o_beat_a, exp_a_q[0]);
            chk(o_beat_b == exp_b_q[0], "beat_b", o_beat_b, exp_b_q[0]);
            chk(o_beat_mask == exp_m_q[0], "beat_mask", o_beat_mask, exp_m_q[0]);
            chk(o_beat_idx == 2'(nb), "beat_idx", o_beat_idx, nb);
            chk(o_beat_sew == s, "beat_sew", o_beat_sew, s);
            lastb = (exp_a_q.size() == 1);
            chk(o_beat_last == lastb, "beat_last", o_beat_last, lastb);
            i_beat_ready = ($urandom_range(99) < ready_pct);
            if (poke && cyc == 1) begin
               i_start = 1'b1; i_op_a = ~a; i_op_b = ~b; i_vl = 5'd1; i_sew = 2'b11;
            end
            if (i_beat_ready) begin
               if (nb == 0) fa = o_beat_a;
               la = o_beat_a; lm = o_beat_mask;
               void'(exp_a_q.pop_front()); void'(exp_b_q.pop_front()); void'(exp_m_q.pop_front());
               nb++;
               if (lastb) exp_done = 1'b1;
            end
         end
         @(negedge clk);
         cyc++;
      end
      i_beat_ready = 1'b0;
      chk(nb == total, "beat_count", nb, total);
   endtask

   typedef struct {
      logic [1:0]   sew;
      logic [4:0]   vl;
      logic [127:0] a;
      bit           poke;
      int           beats;
      logic [31:0]  a0;
      logic [31:0]  alast;
      logic [3:0]   mlast;
   } vec_t;

   vec_t tbl[8];
   logic [127:0] pat;

   initial begin
      int nb;
      logic [31:0] fa, la;
      logic [3:0] lm;
      logic [1:0] rs;
      logic [4:0] rv;
      logic [127:0] ra, rb;

      pat = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
      tbl[0] = '{2'd0, 5'd16, pat, 1'b0, 4, 32'h03020100, 32'h0F0E0D0C, 4'hF};
      tbl[1] = '{2'd1, 5'd3, {128{1'b1}}, 1'b0, 2, 32'hFFFFFFFF, 32'h0000FFFF, 4'b0011};
      tbl[2] = '{2'd2, 5'd20, pat, 1'b0, 4, 32'h03020100, 32'h0F0E0D0C, 4'hF};
      tbl[3] = '{2'd0, 5'd5, pat, 1'b0, 2, 32'h03020100, 32'h00000004, 4'b0001};
      tbl[4] = '{2'd2, 5'd1, pat, 1'b0, 1, 32'h03020100, 32'h03020100, 4'hF};
      tbl[5] = '{2'd1, 5'd31, pat, 1'b0, 4, 32'h03020100, 32'h0F0E0D0C, 4'hF};
      tbl[6] = '{2'd0, 5'd0, pat, 1'b0, 0, 32'h0, 32'h0, 4'h0};
      tbl[7] = '{2'd0, 5'd16, pat, 1'b1, 4, 32'h03020100, 32'h0F0E0D0C, 4'hF};

      // Reset
      i_reset = 1'b1;
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      chk(o_beat_valid == 1'b0, "rst_valid", o_beat_valid, 0);
      chk(o_busy == 1'b0, "rst_busy", o_busy, 0);
      chk(o_done == 1'b0, "rst_done", o_done, 0);
      chk(o_beat_a == '0, "rst_beat_a", o_beat_a, 0);
      chk(o_beat_mask == '0, "rst_mask", o_beat_mask, 0);
      chk(o_dbg_state == 2'd0, "rst_state", o_dbg_state, 0);

      // Table vectors, full-rate consumer
      for (int t = 0; t < 8; t++) begin
         run_xfer(tbl[t].sew, tbl[t].vl, tbl[t].a, ~tbl[t].a, 100, tbl[t].poke, nb, fa, la, lm);
         chk(nb == tbl[t].beats, $sformatf("tbl%0d_beats", t), nb, tbl[t].beats);
         chk(fa == tbl[t].a0, $sformatf("tbl%0d_first_a", t), fa, tbl[t].a0);
         chk(la == tbl[t].alast, $sformatf("tbl%0d_last_a", t), la, tbl[t].alast);
         chk(lm == tbl[t].mlast, $sformatf("tbl%0d_last_mask", t), lm, tbl[t].mlast);
      end

      // Illegal SEW
      @(negedge clk);
      i_start = 1'b1; i_sew = 2'b11; i_vl = 5'd4;
      @(negedge clk);
      i_start = 1'b0;
      chk(o_sew_err == 1'b1, "sew_err_pulse", o_sew_err, 1);
      chk(o_busy == 1'b0, "sew_err_busy", o_busy, 0);
      chk(o_beat_valid == 1'b0, "sew_err_valid", o_beat_valid, 0);
      @(negedge clk);
      chk(o_sew_err == 1'b0, "sew_err_one_cycle", o_sew_err, 0);

      // Backpressure at beat 1
      i_start = 1'b1; i_sew = 2'b00; i_vl = 5'd16; i_op_a = pat; i_op_b = pat;
      @(negedge clk);
      i_start = 1'b0;
      i_beat_ready = 1'b1;
      chk(o_beat_idx == 2'd0, "bp_idx0", o_beat_idx, 0);
      @(negedge clk);
      i_beat_ready = 1'b0;
      chk(o_beat_idx == 2'd1, "bp_idx1", o_beat_idx, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk(o_beat_valid == 1'b1, "bp_valid_hold", o_beat_valid, 1);
         chk(o_beat_idx == 2'd1, "bp_idx_hold", o_beat_idx, 1);
         chk(o_beat_a == 32'h07060504, "bp_a_hold", o_beat_a, 32'h07060504);
         chk(o_beat_mask == 4'hF, "bp_mask_hold", o_beat_mask, 4'hF);
      end
      i_beat_ready = 1'b1;
      @(negedge clk);
      chk(o_beat_idx == 2'd2, "bp_advance", o_beat_idx, 2);
      chk(o_beat_a == 32'h0B0A0908, "bp_a2", o_beat_a, 32'h0B0A0908);
      @(negedge clk);
      chk(o_beat_last == 1'b1, "bp_last", o_beat_last, 1);
      @(negedge clk);
      i_beat_ready = 1'b0;
      chk(o_done == 1'b1, "bp_done", o_done, 1);
      @(negedge clk);

      // Mid-stream reset with beat 2 pending
      i_start = 1'b1; i_sew = 2'b01; i_vl = 5'd8; i_op_a = pat; i_op_b = ~pat;
      @(negedge clk);
      i_start = 1'b0;
      i_beat_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_beat_ready = 1'b0;
      chk(o_beat_idx == 2'd2, "mr_pending_idx", o_beat_idx, 2);
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      chk(o_beat_valid == 1'b0, "mr_valid", o_beat_valid, 0);
      chk(o_beat_a == '0, "mr_a", o_beat_a, 0);
      chk(o_beat_b == '0, "mr_b", o_beat_b, 0);
      chk(o_beat_mask == '0, "mr_mask", o_beat_mask, 0);
      chk(o_beat_idx == '0, "mr_idx", o_beat_idx, 0);
      chk(o_beat_sew == '0, "mr_sew", o_beat_sew, 0);
      chk(o_beat_last == 1'b0, "mr_last", o_beat_last, 0);
      chk(o_busy == 1'b0, "mr_busy", o_busy, 0);
      run_xfer(2'b01, 5'd8, pat, ~pat, 70, 1'b0, nb, fa, la, lm);
      chk(fa == 32'h03020100, "mr_restart_first", fa, 32'h03020100);

      // Randomized transfers against the model
      for (int r = 0; r < 25; r++) begin
         rs = 2'($urandom_range(2));
         rv = 5'($urandom_range(31));
         ra = {$urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom};
         run_xfer(rs, rv, ra, rb, $urandom_range(100, 30), 1'($urandom_range(1)), nb, fa, la, lm);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
